// File: rtl/disp_pkg.sv
// Shared constants for the hex 7-segment overlay: segment indices, hex decode table
// and the segment-height helper used by the geometry logic.
package disp_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Bit order is {g,f,e,d,c,b,a}; b/e are the left column, c/f the right column.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1110111, 7'b0100100, 7'b1011101, 7'b1101101,
    7'b0101110, 7'b1101011, 7'b1111011, 7'b0100111,
    7'b1111111, 7'b1101111, 7'b0111111, 7'b1111010,
    7'b1010011, 7'b1110111, 7'b1011011, 7'b0011011
  };

  function automatic int seg_height(int dig_h, int boundary, int thickness);
    return (dig_h - 2 * boundary - 3 * thickness) / 2;
  endfunction

endpackage

// File: rtl/disp_seg_hit.sv
// Combinational segment geometry: decides whether local cell coordinate (x, y)
// falls inside one of the segments enabled in mask.
module disp_seg_hit
  import disp_pkg::*;
#(
  parameter int DIG_W     = 64,
  parameter int DIG_H     = 96,
  parameter int BOUNDARY  = 5,
  parameter int THICKNESS = 5,
  parameter int CNT_W     = 11
) (
  input  logic [CNT_W-1:0] x,
  input  logic [CNT_W-1:0] y,
  input  logic [6:0]       mask,
  output logic             hit
);

  localparam int B  = BOUNDARY;
  localparam int T  = THICKNESS;
  localparam int SH = seg_height(DIG_H, BOUNDARY, THICKNESS);

  int         xi;
  int         yi;
  logic       x_l, x_m, x_r;
  logic       y_a, y_up, y_d, y_lo, y_g;
  logic [6:0] seg;

  always_comb begin
    xi = int'(x);
    yi = int'(y);
    x_l  = (xi >= B)             && (xi < B + T);
    x_m  = (xi >= B + T)         && (xi < DIG_W - B - T);
    x_r  = (xi >= DIG_W - B - T) && (xi < DIG_W - B);
    y_a  = (yi >= B)                  && (yi < B + T);
    y_up = (yi >= B + T)              && (yi < B + T + SH);
    y_d  = (yi >= B + T + SH)         && (yi < B + 2 * T + SH);
    y_lo = (yi >= B + 2 * T + SH)     && (yi < B + 2 * T + 2 * SH);
    y_g  = (yi >= B + 2 * T + 2 * SH) && (yi < B + 3 * T + 2 * SH);

    seg        = '0;
    seg[SEG_A] = y_a  & x_m;
    seg[SEG_B] = y_up & x_l;
    seg[SEG_C] = y_up & x_r;
    seg[SEG_D] = y_d  & x_m;
    seg[SEG_E] = y_lo & x_l;
    seg[SEG_F] = y_lo & x_r;
    seg[SEG_G] = y_g  & x_m;
    hit        = |(seg & mask);
  end

endmodule

// File: rtl/disp_hex_num.sv
// N-digit hex 7-segment overlay on the pixel stream. Frame-latched value/position/mode,
// fixed two-stage pipeline: stage 1 finds the cell and its segment mask, stage 2 the geometry.
module disp_hex_num
  import disp_pkg::*;
#(
  parameter int          NUM_DIGITS   = 4,
  parameter int          DIG_W        = 64,
  parameter int          DIG_H        = 96,
  parameter int          BOUNDARY     = 5,
  parameter int          THICKNESS    = 5,
  parameter int          CNT_W        = 11,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [23:0] FG_RGB       = 24'h000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_frame_start,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [CNT_W-1:0]        i_pos_h,
  input  logic [CNT_W-1:0]        i_pos_v,
  input  logic [1:0]              i_mode,
  input  logic                    i_enable,
  input  logic [7:0]              i_red,
  input  logic [7:0]              i_grn,
  input  logic [7:0]              i_blu,
  input  logic [CNT_W-1:0]        cnt_h,
  input  logic [CNT_W-1:0]        cnt_v,
  output logic [7:0]              o_red,
  output logic [7:0]              o_grn,
  output logic [7:0]              o_blu,
  output logic                    o_hit
);

  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] val_q;
  logic [CNT_W-1:0]        pos_h_q, pos_v_q;
  logic [1:0]              mode_q;
  logic                    en_q;
  logic [BW-1:0]           blink_cnt;
  logic                    blink_phase;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make results depend on process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q       <= '0;
      pos_h_q     <= '0;
      pos_v_q     <= '0;
      mode_q      <= '0;
      en_q        <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (i_frame_start) begin
      val_q   <= i_value;
      pos_h_q <= i_pos_h;
      pos_v_q <= i_pos_v;
      mode_q  <= i_mode;
      en_q    <= i_enable;
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Stage 1: box test on CNT_W+1 bits so a box past the raster edge clips instead of wrapping.
  logic [CNT_W:0]          h_lo, h_hi, v_lo, v_hi;
  logic                    in_box;
  logic [CNT_W-1:0]        dx, dy, lx;
  logic [IW-1:0]           idx;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    nz_seen;
  logic [3:0]              nib;
  logic                    dig_blank;
  logic                    show;

  // NOTE: every variable in always_comb gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    h_lo   = {1'b0, pos_h_q};
    v_lo   = {1'b0, pos_v_q};
    h_hi   = h_lo + (CNT_W + 1)'(NUM_DIGITS * DIG_W);
    v_hi   = v_lo + (CNT_W + 1)'(DIG_H);
    in_box = ({1'b0, cnt_h} >= h_lo) && ({1'b0, cnt_h} < h_hi) &&
             ({1'b0, cnt_v} >= v_lo) && ({1'b0, cnt_v} < v_hi);
    dx = cnt_h - pos_h_q;
    dy = cnt_v - pos_v_q;

    idx = '0;
    lx  = dx;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (dx >= CNT_W'(k * DIG_W)) begin
        idx = IW'(k);
        lx  = dx - CNT_W'(k * DIG_W);
      end
    end

    blank   = '0;
    nz_seen = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      nz_seen  = nz_seen | (val_q[4*(NUM_DIGITS-1-k) +: 4] != 4'h0);
      blank[k] = ~nz_seen && (k != NUM_DIGITS - 1);
    end

    nib       = '0;
    dig_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        nib       = val_q[4*(NUM_DIGITS-1-k) +: 4];
        dig_blank = blank[k];
      end
    end

    show = en_q & in_box & ~(mode_q[1] & blink_phase) & ~(mode_q[0] & dig_blank);
  end

  logic [CNT_W-1:0] lx_q, ly_q;
  logic [6:0]       mask_q;
  logic [23:0]      rgb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lx_q   <= '0;
      ly_q   <= '0;
      mask_q <= '0;
      rgb_q  <= '0;
    end else begin
      lx_q   <= lx;
      ly_q   <= dy;
      mask_q <= show ? HEX_SEG[nib] : 7'b0;
      rgb_q  <= {i_red, i_grn, i_blu};
    end
  end

  // Stage 2: segment geometry and colour mux.
  logic seg_hit;

  disp_seg_hit #(
    .DIG_W    (DIG_W),
    .DIG_H    (DIG_H),
    .BOUNDARY (BOUNDARY),
    .THICKNESS(THICKNESS),
    .CNT_W    (CNT_W)
  ) u_seg_hit (
    .x   (lx_q),
    .y   (ly_q),
    .mask(mask_q),
    .hit (seg_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_hit                 <= 1'b0;
      {o_red, o_grn, o_blu} <= '0;
    end else begin
      o_hit                 <= seg_hit;
      {o_red, o_grn, o_blu} <= seg_hit ? FG_RGB : rgb_q;
    end
  end

endmodule

// File: tb/tb_disp_hex_num.sv
// Self-checking bench for disp_hex_num: directed vectors plus randomized pixels
// checked against a frame-level reference model of the overlay.
module tb_disp_hex_num;

  localparam int          ND    = 4;
  localparam int          DW    = 64;
  localparam int          DH    = 96;
  localparam int          B     = 5;
  localparam int          T     = 5;
  localparam int          CW    = 11;
  localparam int          BLINK = 2;
  localparam logic [23:0] FG    = 24'hF0E1D2;
  localparam int          SH    = (DH - 2 * B - 3 * T) / 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_frame_start = 1'b0;
  logic [15:0]   i_value = '0;
  logic [CW-1:0] i_pos_h = '0, i_pos_v = '0;
  logic [1:0]    i_mode = '0;
  logic          i_enable = 1'b0;
  logic [7:0]    i_red = '0, i_grn = '0, i_blu = '0;
  logic [CW-1:0] cnt_h = '0, cnt_v = '0;
  logic [7:0]    o_red, o_grn, o_blu;
  logic          o_hit;

  always #5 clk = ~clk;

  disp_hex_num #(
    .NUM_DIGITS(ND), .DIG_W(DW), .DIG_H(DH), .BOUNDARY(B), .THICKNESS(T),
    .CNT_W(CW), .BLINK_FRAMES(BLINK), .FG_RGB(FG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_frame_start(i_frame_start), .i_value(i_value),
    .i_pos_h(i_pos_h), .i_pos_v(i_pos_v), .i_mode(i_mode), .i_enable(i_enable),
    .i_red(i_red), .i_grn(i_grn), .i_blu(i_blu), .cnt_h(cnt_h), .cnt_v(cnt_v),
    .o_red(o_red), .o_grn(o_grn), .o_blu(o_blu), .o_hit(o_hit)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model state: what the overlay should have latched so far.
  logic [15:0] m_val = '0;
  int          m_ph = 0, m_pv = 0, m_pulses = 0;
  logic [1:0]  m_mode = '0;
  logic        m_en = 1'b0;

  // Values to present on the frame-latch inputs from the next step onward.
  logic [15:0] nv_val = '0;
  int          nv_ph = 0, nv_pv = 0;
  logic [1:0]  nv_mode = '0;
  logic        nv_en = 1'b0;

  string seg_str [16] = '{"abcefg", "cf", "acdeg", "acdfg", "bcdf", "abdfg", "abdefg", "abcf",
                          "abcdefg", "abcdfg", "abcdef", "bdefg", "abeg", "abcefg", "abdeg", "abde"};

  function automatic string seg_at(int lx, int ly);
    bit xm, xl, xr;
    xm = lx >= B + T && lx < DW - B - T;
    xl = lx >= B && lx < B + T;
    xr = lx >= DW - B - T && lx < DW - B;
    if (ly >= B && ly < B + T && xm) return "a";
    if (ly >= B + T && ly < B + T + SH) return xl ? "b" : (xr ? "c" : "");
    if (ly >= B + T + SH && ly < B + 2 * T + SH && xm) return "d";
    if (ly >= B + 2 * T + SH && ly < B + 2 * T + 2 * SH) return xl ? "e" : (xr ? "f" : "");
    if (ly >= B + 2 * T + 2 * SH && ly < B + 3 * T + 2 * SH && xm) return "g";
    return "";
  endfunction

  function automatic logic model_hit(int h, int v);
    int    dx, dy, dig, nib;
    string s, lit;
    if (!m_en) return 1'b0;
    if (m_mode[1] && ((m_pulses / BLINK) % 2 == 1)) return 1'b0;
    dx = h - m_ph;
    dy = v - m_pv;
    if (dx < 0 || dx >= ND * DW || dy < 0 || dy >= DH) return 1'b0;
    dig = dx / DW;
    if (m_mode[0] && dig != ND - 1 && (int'(m_val) >> (4 * (ND - 1 - dig))) == 0) return 1'b0;
    nib = (int'(m_val) >> (4 * (ND - 1 - dig))) & 15;
    s = seg_at(dx % DW, dy);
    if (s.len() == 0) return 1'b0;
    lit = seg_str[nib];
    for (int i = 0; i < lit.len(); i++)
      if (lit[i] == s[0]) return 1'b1;
    return 1'b0;
  endfunction

  typedef struct {
    string       name;
    logic        hit;
    logic [23:0] rgb;
  } exp_t;

  exp_t exp_q [$];

  // One pixel per call: check the pixel from two steps ago, then drive a new one.
  task automatic step(input string name, input logic fs, input int h, input int v,
                      input logic use_model, input logic exp_hit);
    exp_t        e;
    logic [23:0] rgb;
    @(negedge clk);
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      check({e.name, "_hit"}, {31'b0, o_hit}, {31'b0, e.hit});
      check({e.name, "_rgb"}, {8'b0, o_red, o_grn, o_blu}, {8'b0, e.rgb});
    end
    rgb = 24'($urandom);
    i_value = nv_val; i_pos_h = CW'(nv_ph); i_pos_v = CW'(nv_pv);
    i_mode = nv_mode; i_enable = nv_en;
    i_frame_start = fs;
    cnt_h = CW'(h); cnt_v = CW'(v);
    {i_red, i_grn, i_blu} = rgb;
    e.name = name;
    e.hit  = use_model ? model_hit(h, v) : exp_hit;
    e.rgb  = e.hit ? FG : rgb;
    exp_q.push_back(e);
    if (fs) begin
      m_val = nv_val; m_ph = nv_ph; m_pv = nv_pv; m_mode = nv_mode; m_en = nv_en;
      m_pulses++;
    end
  endtask

  task automatic set_frame(input logic [15:0] val, input int ph, input int pv,
                           input logic [1:0] mode, input logic en);
    nv_val = val; nv_ph = ph; nv_pv = pv; nv_mode = mode; nv_en = en;
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    i_frame_start = 1'b0;
    rst_n = 1'b0;
    #1;
    check({name, "_hit"}, {31'b0, o_hit}, 32'd0);
    check({name, "_rgb"}, {8'b0, o_red, o_grn, o_blu}, 32'd0);
    exp_q.delete();
    m_val = '0; m_ph = 0; m_pv = 0; m_mode = '0; m_en = 1'b0; m_pulses = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    string name;
    int    h;
    int    v;
    logic  hit;
  } vec_t;

  vec_t tbl [10];
  logic vis [5];

  initial begin
    // Value 16'h1234 at (100,50), mode 0: digits "1","2","3","4".
    tbl[0] = '{"d1_a",   174,  55, 1'b1};
    tbl[1] = '{"left",    99,  55, 1'b0};
    tbl[2] = '{"d0_b",   105,  62, 1'b0};
    tbl[3] = '{"d0_c",   156,  62, 1'b1};
    tbl[4] = '{"d3_d",   312,  97, 1'b1};
    tbl[5] = '{"d3_g",   312, 137, 1'b0};
    tbl[6] = '{"d2_g",   248, 137, 1'b1};
    tbl[7] = '{"below",  120, 146, 1'b0};
    tbl[8] = '{"d2_e",   235, 110, 1'b0};
    tbl[9] = '{"d2_f",   284, 110, 1'b1};
    vis = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    #3;
    do_reset("rst0");
    set_frame(16'h1234, 100, 50, 2'b00, 1'b1);
    step("pre_frame_in_box", 1'b0, 174, 55, 1'b0, 1'b0);
    step("pre_frame_c",      1'b0, 156, 62, 1'b0, 1'b0);
    step("pulse_old_copy",   1'b1, 174, 55, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(tbl[i].name, 1'b0, tbl[i].h, tbl[i].v, 1'b0, tbl[i].hit);

    // Leading-zero blanking.
    set_frame(16'h0007, 100, 50, 2'b01, 1'b1);
    step("lz_pulse", 1'b1, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < ND; k++) step($sformatf("lz7_a%0d", k), 1'b0, 120 + 64 * k, 57, 1'b0, k == ND - 1);
    step("lz7_d3", 1'b0, 312, 97, 1'b0, 1'b0);
    step("lz7_c3", 1'b0, 348, 62, 1'b0, 1'b1);
    set_frame(16'h0000, 100, 50, 2'b01, 1'b1);
    step("lz0_pulse", 1'b1, 0, 0, 1'b0, 1'b0);
    step("lz0_a2", 1'b0, 248, 57, 1'b0, 1'b0);
    step("lz0_a3", 1'b0, 312, 57, 1'b0, 1'b1);
    step("lz0_d3", 1'b0, 312, 97, 1'b0, 1'b0);
    step("lz0_b3", 1'b0, 299, 62, 1'b0, 1'b1);

    // No tearing: value change between pulses is ignored until the next pulse.
    set_frame(16'hAAAA, 100, 50, 2'b00, 1'b1);
    step("tear_pulse", 1'b1, 0, 0, 1'b0, 1'b0);
    step("tear_A", 1'b0, 156, 62, 1'b0, 1'b1);
    nv_val = 16'h5555;
    repeat (3) step("tear_hold", 1'b0, 156, 62, 1'b0, 1'b1);
    step("tear_edge", 1'b1, 156, 62, 1'b0, 1'b1);
    step("tear_5", 1'b0, 156, 62, 1'b0, 1'b0);
    step("tear_5a", 1'b0, 120, 57, 1'b0, 1'b1);

    // Clipping near the raster edge.
    set_frame(16'h8888, 2000, 50, 2'b00, 1'b1);
    step("clip_pulse", 1'b1, 0, 0, 1'b0, 1'b0);
    for (int h = 0; h <= 20; h++) step($sformatf("clip_h%0d", h), 1'b0, h, 57, 1'b0, 1'b0);
    step("clip_in",   1'b0, 2010, 57, 1'b0, 1'b1);
    step("clip_edge", 1'b0, 2047, 57, 1'b0, 1'b1);

    // Mid-stream reset, then blink with BLINK_FRAMES=2.
    do_reset("rst_mid");
    set_frame(16'h8888, 100, 50, 2'b10, 1'b1);
    for (int f = 0; f < 5; f++) begin
      step($sformatf("blink_pulse%0d", f + 1), 1'b1, 120, 57, 1'b1, 1'b0);
      step($sformatf("blink_f%0d", f + 1), 1'b0, 120, 57, 1'b0, vis[f]);
      step($sformatf("blink_g%0d", f + 1), 1'b0, 120, 137, 1'b0, vis[f]);
    end

    // Randomized frames and pixels against the model.
    for (int i = 0; i < 1500; i++) begin
      logic fs;
      fs = ($urandom_range(0, 39) == 0);
      if (fs) begin
        nv_val  = 16'($urandom >> $urandom_range(0, 16));
        nv_ph   = $urandom_range(0, 1900);
        nv_pv   = $urandom_range(0, 2000);
        nv_mode = 2'($urandom);
        nv_en   = ($urandom_range(0, 7) != 0);
      end else if ($urandom_range(0, 99) == 0) begin
        nv_val = 16'($urandom);
      end
      step("rnd", fs,
           (m_ph + $urandom_range(0, 300) - 20 + 2048) % 2048,
           (m_pv + $urandom_range(0, 120) - 10 + 2048) % 2048,
           1'b1, 1'b0);
    end
    repeat (2) step("drain", 1'b0, 0, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
